// File: rtl/input_tile_fetcher.sv
// -----------------------------------------------------------------------------
// input_tile_fetcher
//
// Read-side controller for the dual-port input data memory. A start command
// walks a run of 4-row Winograd input tiles. Each tile takes two paired
// issues: rows 0/1, then rows 2/3. Even rows go out on memory port 1 and odd
// rows on port 2. Returned rows are captured into a small credit-protected
// FIFO and handed downstream as row pairs under valid/ready flow control.
//
// Ports
//   clk, reset                  single clock, synchronous active-high reset
//   scan_mode_in                memory under scan load: no start, no issue
//   start_in                    one-cycle command pulse
//   base_addr_in                address of row 0 of tile 0
//   tile_count_in               number of tiles in the run
//   tile_stride_in              address step between consecutive tiles
//   busy_out                    command in progress
//   done_out                    one-cycle pulse after the final pair is taken
//   err_out                     sticky: the two port valids came back unpaired
//   addr_1_out / addr_2_out     read addresses for memory ports 1 / 2
//   addr_1_valid_out / _2_      read requests (always equal)
//   data_1_in / data_2_in       returned rows
//   data_1_valid_in / _2_       returned-row valids
//   row_a_out / row_b_out       even / odd row of the pair at the FIFO head
//   row_valid_out, row_ready_in downstream handshake
//   row_last_out                final pair of the final tile
// -----------------------------------------------------------------------------
module input_tile_fetcher #(
   parameter int ADDR_W     = 8,
   parameter int DATA_W     = 512,
   parameter int RD_LAT     = 1,
   parameter int FIFO_DEPTH = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              scan_mode_in,
   input  logic              start_in,
   input  logic [ADDR_W-1:0] base_addr_in,
   input  logic [7:0]        tile_count_in,
   input  logic [ADDR_W-1:0] tile_stride_in,
   output logic              busy_out,
   output logic              done_out,
   output logic              err_out,
   output logic [ADDR_W-1:0] addr_1_out,
   output logic [ADDR_W-1:0] addr_2_out,
   output logic              addr_1_valid_out,
   output logic              addr_2_valid_out,
   input  logic [DATA_W-1:0] data_1_in,
   input  logic [DATA_W-1:0] data_2_in,
   input  logic              data_1_valid_in,
   input  logic              data_2_valid_in,
   output logic [DATA_W-1:0] row_a_out,
   output logic [DATA_W-1:0] row_b_out,
   output logic              row_valid_out,
   input  logic              row_ready_in,
   output logic              row_last_out
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   // Counters are sized to cover the FIFO plus the read pipeline.
   localparam int CNT_W = $clog2(FIFO_DEPTH + RD_LAT + 1);
   localparam int OCC_W = CNT_W + 1;

   typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

   state_t            state, state_next;
   logic [ADDR_W-1:0] tile_addr, stride;
   logic [7:0]        tiles_left;
   logic              pair_sel;
   logic [CNT_W-1:0]  fifo_count, inflight;
   logic [OCC_W-1:0]  occupancy;
   logic [PTR_W-1:0]  wr_ptr, rd_ptr;
   logic [DATA_W-1:0] fifo_a [FIFO_DEPTH];
   logic [DATA_W-1:0] fifo_b [FIFO_DEPTH];
   logic [FIFO_DEPTH-1:0] fifo_last;
   logic [ADDR_W-1:0] pair_addr;
   logic start_ok, start_empty, issue, last_issue;
   logic ret_any, ret_pair, ret_err, ret_last, pop, pop_last, drain_done;

   // Handshake decode. Returns are honoured only while something is in
   // flight, which discards stale data from a command abandoned by reset.
   // The final pair is the only one outstanding once the FSM has moved to
   // DRAIN, because returns come back in issue order; that pinpoints which
   // return carries the last flag.
   always_comb begin
      start_ok    = (state == IDLE) && start_in && !scan_mode_in && (tile_count_in != 8'd0);
      start_empty = (state == IDLE) && start_in && !scan_mode_in && (tile_count_in == 8'd0);
      occupancy   = OCC_W'(fifo_count) + OCC_W'(inflight);
      issue       = (state == ISSUE) && !scan_mode_in && (occupancy < OCC_W'(FIFO_DEPTH));
      last_issue  = issue && pair_sel && (tiles_left == 8'd1);
      ret_any     = (data_1_valid_in || data_2_valid_in) && (inflight != '0);
      ret_pair    = ret_any && data_1_valid_in && data_2_valid_in;
      ret_err     = ret_any && (data_1_valid_in != data_2_valid_in);
      ret_last    = (state == DRAIN) && (inflight == CNT_W'(1));
      pop         = row_valid_out && row_ready_in;
      pop_last    = pop && fifo_last[rd_ptr];
      // An empty drain also finishes, so a dropped final pair cannot hang us.
      drain_done  = (state == DRAIN) && (pop_last || ((fifo_count == '0) && (inflight == '0)));
   end

   // State register.
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state logic: IDLE -> ISSUE on an accepted start, ISSUE -> DRAIN on
   // the final issue, DRAIN -> IDLE once the final pair has left.
   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (start_ok)   state_next = ISSUE;
         ISSUE:   if (last_issue) state_next = DRAIN;
         DRAIN:   if (drain_done) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Address walker: tile_addr holds row 0 of the current tile and pair_sel
   // picks rows 0/1 or 2/3. All sums wrap modulo 2^ADDR_W.
   always_ff @(posedge clk) begin
      if (reset) begin
         tile_addr  <= '0;
         stride     <= '0;
         tiles_left <= '0;
         pair_sel   <= 1'b0;
      end else if (start_ok) begin
         tile_addr  <= base_addr_in;
         stride     <= tile_stride_in;
         tiles_left <= tile_count_in;
         pair_sel   <= 1'b0;
      end else if (issue) begin
         pair_sel <= ~pair_sel;
         if (pair_sel) begin
            tile_addr  <= tile_addr + stride;
            tiles_left <= tiles_left - 8'd1;
         end
      end
   end

   // Credit and FIFO bookkeeping, plus the sticky error and the done pulse.
   // Any return frees its credit, including an unpaired one that is discarded.
   always_ff @(posedge clk) begin
      if (reset) begin
         inflight   <= '0;
         fifo_count <= '0;
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         err_out    <= 1'b0;
         done_out   <= 1'b0;
      end else begin
         inflight   <= inflight + CNT_W'(issue) - CNT_W'(ret_any);
         fifo_count <= fifo_count + CNT_W'(ret_pair) - CNT_W'(pop);
         if (ret_pair) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)      rd_ptr <= rd_ptr + PTR_W'(1);
         if (ret_err)  err_out <= 1'b1;
         done_out <= start_empty || drain_done;
      end
   end

   // FIFO storage needs no reset: the read side is masked while empty.
   always_ff @(posedge clk) begin
      if (ret_pair) begin
         fifo_a[wr_ptr]    <= data_1_in;
         fifo_b[wr_ptr]    <= data_2_in;
         fifo_last[wr_ptr] <= ret_last;
      end
   end

   // Outputs. Addresses read as zero whenever no request is being made.
   always_comb begin
      pair_addr        = tile_addr + ADDR_W'({pair_sel, 1'b0});
      addr_1_valid_out = issue;
      addr_2_valid_out = issue;
      addr_1_out       = issue ? pair_addr : '0;
      addr_2_out       = issue ? (pair_addr + ADDR_W'(1)) : '0;
      busy_out         = (state != IDLE);
      row_valid_out    = (fifo_count != '0);
      row_a_out        = row_valid_out ? fifo_a[rd_ptr] : '0;
      row_b_out        = row_valid_out ? fifo_b[rd_ptr] : '0;
      row_last_out     = row_valid_out && fifo_last[rd_ptr];
   end

endmodule

// File: tb/tb_input_tile_fetcher.sv
// -----------------------------------------------------------------------------
// tb_input_tile_fetcher
//
// Testbench for input_tile_fetcher. A fixed-latency dual-port memory model
// holds random row contents. The tile-walk reference turns each command into
// an ordered list of address pairs and row pairs. A monitor compares every
// issued request and every accepted pair against that list, and it bounds
// the number of outstanding pairs by the FIFO depth.
// -----------------------------------------------------------------------------
module tb_input_tile_fetcher;

   localparam int ADDR_W     = 8;
   localparam int DATA_W     = 512;
   localparam int RD_LAT     = 1;
   localparam int FIFO_DEPTH = 4;

   typedef struct {
      logic [DATA_W-1:0] a;
      logic [DATA_W-1:0] b;
      logic              last;
   } pair_t;

   logic              clk = 1'b0;
   logic              reset;
   logic              scan_mode_in;
   logic              start_in;
   logic [ADDR_W-1:0] base_addr_in;
   logic [7:0]        tile_count_in;
   logic [ADDR_W-1:0] tile_stride_in;
   logic              busy_out, done_out, err_out;
   logic [ADDR_W-1:0] addr_1_out, addr_2_out;
   logic              addr_1_valid_out, addr_2_valid_out;
   logic [DATA_W-1:0] data_1_in, data_2_in;
   logic              data_1_valid_in = 1'b0;
   logic              data_2_valid_in = 1'b0;
   logic [DATA_W-1:0] row_a_out, row_b_out;
   logic              row_valid_out, row_ready_in, row_last_out;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;
   int outstanding = 0;
   int issue_mark, pop_mark;
   bit rand_mode;
   logic kill_2;

   logic [DATA_W-1:0] mem_image [256];
   logic [ADDR_W-1:0] exp_a1 [$];
   logic [ADDR_W-1:0] exp_a2 [$];
   pair_t             exp_pair [$];
   int                issue_cyc_log [$];
   int                pop_cyc_log [$];

   input_tile_fetcher #(
      .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT), .FIFO_DEPTH(FIFO_DEPTH)
   ) dut (
      .clk(clk), .reset(reset), .scan_mode_in(scan_mode_in), .start_in(start_in),
      .base_addr_in(base_addr_in), .tile_count_in(tile_count_in),
      .tile_stride_in(tile_stride_in), .busy_out(busy_out), .done_out(done_out),
      .err_out(err_out), .addr_1_out(addr_1_out), .addr_2_out(addr_2_out),
      .addr_1_valid_out(addr_1_valid_out), .addr_2_valid_out(addr_2_valid_out),
      .data_1_in(data_1_in), .data_2_in(data_2_in),
      .data_1_valid_in(data_1_valid_in), .data_2_valid_in(data_2_valid_in),
      .row_a_out(row_a_out), .row_b_out(row_b_out), .row_valid_out(row_valid_out),
      .row_ready_in(row_ready_in), .row_last_out(row_last_out)
   );

   // Free-running clock and a cycle counter used for latency measurements.
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Memory model with a one-cycle read latency. While kill_2 is high, port 2
   // withholds its valid to mimic an unpaired return.
   always @(posedge clk) begin
      data_1_in       <= mem_image[addr_1_out];
      data_2_in       <= mem_image[addr_2_out];
      data_1_valid_in <= addr_1_valid_out;
      data_2_valid_in <= addr_2_valid_out && !kill_2;
   end

   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      checks++;
      assert (observed === expected) else begin
         failures++;
         $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   task automatic checkRow(input string tag, input logic [DATA_W-1:0] observed, input logic [DATA_W-1:0] expected);
      checks++;
      assert (observed === expected) else begin
         failures++;
         $error("[TB] FAIL %s: observed[63:0]=%h expected[63:0]=%h", tag, observed[63:0], expected[63:0]);
      end
   endtask

   // Reference tile walk: tile-major, pair-minor, with addresses modulo 256.
   task automatic loadCommand(input logic [7:0] base, input logic [7:0] count, input logic [7:0] stride);
      for (int t = 0; t < int'(count); t++) begin
         for (int k = 0; k < 2; k++) begin
            int    a1;
            pair_t p;
            a1 = (int'(base) + t * int'(stride) + 2 * k) % 256;
            exp_a1.push_back(8'(a1));
            exp_a2.push_back(8'((a1 + 1) % 256));
            p.a    = mem_image[a1];
            p.b    = mem_image[(a1 + 1) % 256];
            p.last = (t == int'(count) - 1) && (k == 1);
            exp_pair.push_back(p);
         end
      end
   endtask

   // Pulse start for one cycle. When the command is expected to run, load
   // the reference first. Returns at the negedge of the first issue cycle.
   task automatic applyStimulus(input logic [7:0] base, input logic [7:0] count,
                                input logic [7:0] stride, input bit accept);
      issue_mark = issue_cyc_log.size();
      pop_mark   = pop_cyc_log.size();
      if (accept) loadCommand(base, count, stride);
      base_addr_in   = base;
      tile_count_in  = count;
      tile_stride_in = stride;
      start_in       = 1'b1;
      @(negedge clk);
      start_in = 1'b0;
   endtask

   task automatic checkResetState(input string tag);
      checkOutput({tag, "_busy"}, busy_out, 0);
      checkOutput({tag, "_done"}, done_out, 0);
      checkOutput({tag, "_err"}, err_out, 0);
      checkOutput({tag, "_addr_valids"}, {addr_1_valid_out, addr_2_valid_out}, 0);
      checkOutput({tag, "_addrs"}, {addr_1_out, addr_2_out}, 0);
      checkOutput({tag, "_row_valid_last"}, {row_valid_out, row_last_out}, 0);
      checkRow({tag, "_row_a"}, row_a_out, '0);
      checkRow({tag, "_row_b"}, row_b_out, '0);
   endtask

   // Wait for done_out within a cycle budget. In random mode, randomise
   // ready and scan mode on every cycle while waiting.
   task automatic waitDone(input int budget);
      int n;
      bit seen;
      n    = 0;
      seen = 0;
      while (!seen && n < budget) begin
         @(negedge clk);
         n++;
         if (done_out) seen = 1;
         else if (rand_mode) begin
            row_ready_in = $urandom_range(0, 1);
            scan_mode_in = ($urandom_range(0, 3) == 0);
         end
      end
      checkOutput("done_seen", seen, 1);
      if (seen) begin
         checkOutput("done_after_last_pop", cyc - pop_cyc_log[pop_cyc_log.size() - 1], 1);
         checkOutput("busy_cleared", busy_out, 0);
         checkOutput("addr_list_drained", exp_a1.size(), 0);
         checkOutput("pair_list_drained", exp_pair.size(), 0);
         @(negedge clk);
         checkOutput("done_one_cycle", done_out, 0);
      end
      row_ready_in = 1'b1;
      scan_mode_in = 1'b0;
   endtask

   // Monitor: samples 3 time units after each negedge, away from both edges.
   always begin : monitor
      logic [ADDR_W-1:0] e1, e2;
      pair_t p;
      @(negedge clk);
      #3;
      if (reset) begin
         outstanding = 0;
      end else begin
         if (addr_1_valid_out || addr_2_valid_out) begin
            issue_cyc_log.push_back(cyc);
            outstanding++;
            if (kill_2) outstanding--;
            checkOutput("issue_both_valid", {addr_1_valid_out, addr_2_valid_out}, 2'b11);
            checkOutput("issue_expected", exp_a1.size() > 0, 1);
            if (exp_a1.size() > 0) begin
               e1 = exp_a1.pop_front();
               e2 = exp_a2.pop_front();
               checkOutput("addr_1", addr_1_out, e1);
               checkOutput("addr_2", addr_2_out, e2);
            end
            checkOutput("credit_bound", outstanding <= FIFO_DEPTH, 1);
         end
         if (row_valid_out && row_ready_in) begin
            pop_cyc_log.push_back(cyc);
            outstanding--;
            checkOutput("pop_expected", exp_pair.size() > 0, 1);
            if (exp_pair.size() > 0) begin
               p = exp_pair.pop_front();
               checkRow("row_a", row_a_out, p.a);
               checkRow("row_b", row_b_out, p.b);
               checkOutput("row_last", row_last_out, p.last);
            end
         end
      end
   end

   // Safety net so the run always ends.
   initial begin
      #400000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   // Directed sequence followed by randomized commands.
   initial begin
      logic [7:0] rb, rs, rc;
      for (int i = 0; i < 256; i++)
         for (int j = 0; j < DATA_W / 32; j++)
            mem_image[i][j*32 +: 32] = $urandom();
      reset = 1'b1; scan_mode_in = 1'b0; start_in = 1'b0; kill_2 = 1'b0;
      base_addr_in = '0; tile_count_in = '0; tile_stride_in = '0;
      row_ready_in = 1'b1; rand_mode = 0;
      repeat (3) @(negedge clk);
      checkResetState("reset");
      reset = 1'b0;
      @(negedge clk);

      $display("[TB] base 0x10 stride 4 count 3, ready high");
      applyStimulus(8'h10, 8'd3, 8'd4, 1);
      checkOutput("t1_busy", busy_out, 1);
      checkOutput("t1_first_issue", addr_1_valid_out, 1);
      waitDone(100);
      checkOutput("t1_issues", issue_cyc_log.size() - issue_mark, 6);
      checkOutput("t1_back_to_back", issue_cyc_log[issue_cyc_log.size() - 1] - issue_cyc_log[issue_mark], 5);
      checkOutput("t1_row_latency", pop_cyc_log[pop_mark] - issue_cyc_log[issue_mark], 2);
      checkOutput("t1_pops", pop_cyc_log.size() - pop_mark, 6);

      $display("[TB] wrapping addresses");
      applyStimulus(8'hFC, 8'd2, 8'd2, 1);
      waitDone(100);

      $display("[TB] downstream stalled for 20 cycles");
      row_ready_in = 1'b0;
      rb = 8'($urandom_range(0, 255));
      rs = 8'($urandom_range(0, 255));
      applyStimulus(rb, 8'd4, rs, 1);
      repeat (19) @(negedge clk);
      checkOutput("stall_issues", issue_cyc_log.size() - issue_mark, FIFO_DEPTH);
      checkOutput("stall_no_request", addr_1_valid_out, 0);
      checkOutput("stall_row_valid", row_valid_out, 1);
      row_ready_in = 1'b1;
      waitDone(200);
      checkOutput("stall_total_issues", issue_cyc_log.size() - issue_mark, 8);

      $display("[TB] zero-tile command");
      applyStimulus(8'h55, 8'd0, 8'h03, 0);
      checkOutput("zero_done", done_out, 1);
      checkOutput("zero_busy", busy_out, 0);
      @(negedge clk);
      checkOutput("zero_done_one_cycle", done_out, 0);
      checkOutput("zero_issues", issue_cyc_log.size() - issue_mark, 0);

      $display("[TB] scan mode");
      scan_mode_in = 1'b1;
      applyStimulus(8'h40, 8'd3, 8'h08, 0);
      @(negedge clk);
      checkOutput("scan_start_busy", busy_out, 0);
      checkOutput("scan_start_issues", issue_cyc_log.size() - issue_mark, 0);
      scan_mode_in = 1'b0;
      applyStimulus(8'h40, 8'd3, 8'h08, 1);
      @(negedge clk);
      scan_mode_in = 1'b1;
      repeat (5) begin
         @(negedge clk);
         checkOutput("scan_pause_valid", {addr_1_valid_out, addr_2_valid_out}, 0);
         checkOutput("scan_pause_busy", busy_out, 1);
      end
      checkOutput("scan_pause_issues", issue_cyc_log.size() - issue_mark, 1);
      scan_mode_in = 1'b0;
      waitDone(100);
      checkOutput("scan_total_issues", issue_cyc_log.size() - issue_mark, 6);

      $display("[TB] unpaired return");
      kill_2 = 1'b1;
      applyStimulus(8'h80, 8'd1, 8'h08, 1);
      void'(exp_pair.pop_front());
      @(negedge clk);
      kill_2 = 1'b0;
      waitDone(100);
      checkOutput("err_set", err_out, 1);
      repeat (3) @(negedge clk);
      checkOutput("err_sticky", err_out, 1);

      $display("[TB] reset in the middle of a command");
      row_ready_in = 1'b0;
      applyStimulus(8'h20, 8'd5, 8'h03, 1);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      checkResetState("mid_reset");
      reset = 1'b0;
      exp_a1.delete();
      exp_a2.delete();
      exp_pair.delete();
      row_ready_in = 1'b1;
      repeat (3) @(negedge clk);
      checkOutput("stale_return_ignored", {row_valid_out, err_out, busy_out}, 0);
      applyStimulus(8'h30, 8'd2, 8'h05, 1);
      waitDone(100);

      $display("[TB] randomized commands");
      rand_mode = 1;
      for (int n = 0; n < 6; n++) begin
         rb = 8'($urandom_range(0, 255));
         rs = 8'($urandom_range(0, 255));
         rc = 8'($urandom_range(1, 6));
         scan_mode_in = 1'b0;
         applyStimulus(rb, rc, rs, 1);
         waitDone(400);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
